// File: rtl/cfg_chain_loader.sv
// Loads configuration words serially into an scff chain, then recirculates the
// chain once to compare a readback CRC-8 against the CRC of the written bits.
module cfg_chain_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] data,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              sc_out,
    output logic              sc_en,
    input  logic              sc_in,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CW     = $clog2(CHAIN_LEN + 1);
    localparam int IW     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int NWORDS = CHAIN_LEN / WORD_W;

    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

    state_t            state, state_nxt;
    logic [WORD_W-1:0] shreg;
    logic              held;
    logic [IW-1:0]     bit_idx;
    logic [CW-1:0]     bit_cnt;
    logic [CW-1:0]     word_cnt;
    logic [7:0]        crc_wr, crc_rd;
    logic              err_q;
    logic              word_last, chain_last, accept;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        logic fb;
        fb = crc[7] ^ b;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    assign word_last  = held && (bit_idx == IW'(WORD_W - 1));
    assign chain_last = (bit_cnt == CW'(CHAIN_LEN - 1));
    assign accept     = data_valid && data_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (held && chain_last) state_nxt = VERIFY;
            VERIFY:  if (chain_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // word_cnt gating drops data_ready on the final chain bit without a compare on bit_cnt
    always_comb begin
        data_ready = 1'b0;
        sc_out     = 1'b0;
        sc_en      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = err_q;
        case (state)
            LOAD: begin
                busy       = 1'b1;
                sc_en      = held;
                sc_out     = held & shreg[0];
                data_ready = (word_cnt < CW'(NWORDS)) && (!held || word_last);
            end
            VERIFY: begin
                busy   = 1'b1;
                sc_en  = 1'b1;
                sc_out = sc_in;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
                err  = (crc_rd != crc_wr);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg    <= '0;
            held     <= 1'b0;
            bit_idx  <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            crc_wr   <= '0;
            crc_rd   <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        held     <= 1'b0;
                        bit_idx  <= '0;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                        crc_wr   <= '0;
                        crc_rd   <= '0;
                        err_q    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (held) begin
                        crc_wr  <= crc8_step(crc_wr, shreg[0]);
                        bit_cnt <= chain_last ? '0 : bit_cnt + CW'(1);
                    end
                    if (accept) begin
                        shreg    <= data;
                        held     <= 1'b1;
                        bit_idx  <= '0;
                        word_cnt <= word_cnt + CW'(1);
                    end else if (held) begin
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + IW'(1);
                        if (word_last) held <= 1'b0;
                    end
                end
                VERIFY: begin
                    crc_rd  <= crc8_step(crc_rd, sc_in);
                    bit_cnt <= chain_last ? '0 : bit_cnt + CW'(1);
                end
                DONE: err_q <= (crc_rd != crc_wr);
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cfg_chain_loader.md
CFG_CHAIN_LOADER -- requirements
Module: cfg_chain_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 8, meaning width of each configuration word accepted.
REQ-002 SHALL have parameter CHAIN_LEN, default 64, meaning the number of scff cells in the target configuration chain; it SHALL be a multiple of WORD_W and at least WORD_W.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning a synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  meaning a one-cycle request to begin a load sequence.
REQ-006 SHALL have port data  input  WORD_W  meaning a configuration word, shifted out LSB first.
REQ-007 SHALL have port data_valid  input  1  meaning data holds a valid word.
REQ-008 SHALL have port data_ready  output  1  meaning the block accepts data on this cycle.
REQ-009 SHALL have port sc_out  output  1  meaning the serial bit driven into the chain head D.
REQ-010 SHALL have port sc_en  output  1  meaning the chain shift enable; the chain SHALL advance on each clk edge where sc_en=1.
REQ-011 SHALL have port sc_in  input  1  meaning the chain tail Q, returned to the block.
REQ-012 SHALL have port busy  output  1  meaning a sequence is in progress.
REQ-013 SHALL have port done  output  1  meaning a one-cycle completion pulse.
REQ-014 SHALL have port err  output  1  meaning the readback CRC did not match; it is sticky until the next accepted start.

Function
REQ-015 SHALL implement the states IDLE, LOAD, VERIFY and DONE.
REQ-016 IDLE: start=1 SHALL transition to LOAD, clear err, bit counter and both CRCs; start SHALL be ignored in every other state.
REQ-017 LOAD: data_ready SHALL equal (no word held) OR (held word on its last bit, WORD_W-1); a word SHALL be accepted when data_valid=1 and data_ready=1.
REQ-018 An accepted word SHALL appear on sc_out bit0 on the following cycle with sc_en=1, then one bit per cycle; words may be accepted back-to-back with no bubble.
REQ-019 If no word is held in LOAD, sc_en SHALL be 0 and the chain SHALL hold; data_valid SHALL never be accepted outside LOAD.
REQ-020 Each bit shifted in LOAD SHALL update crc_wr with CRC-8, poly 0x07, init 0x00, MSB-feedback serial form: fb=crc[7]^bit; crc={crc[6:0],0}^(fb?0x07:0).
REQ-021 After exactly CHAIN_LEN shifted bits, the next cycle SHALL enter VERIFY; data_ready SHALL be 0 on the cycle of the final bit if that bit completes the chain.
REQ-022 VERIFY SHALL run CHAIN_LEN cycles with sc_en=1 and sc_out=sc_in (recirculation), which restores the chain contents; each sc_in bit SHALL update crc_rd with the same CRC.
REQ-023 After VERIFY, DONE SHALL last one cycle with done=1 and err=(crc_rd != crc_wr), then return to IDLE.
REQ-024 busy SHALL be 1 in LOAD, VERIFY and DONE, and 0 in IDLE; sc_en SHALL be 0 in IDLE and DONE.
REQ-025 Bit and word counters SHALL be sized as clog2(CHAIN_LEN+1) bits and SHALL not wrap within a sequence.

Reset
REQ-026 While reset=1 at an edge, the block SHALL enter IDLE with sc_out=0, sc_en=0, data_ready=0, busy=0, done=0, err=0, and counters/CRCs cleared; this SHALL take priority over start and apply mid-sequence (a partially shifted chain is abandoned).

Verification
REQ-027 WORD_W=8, CHAIN_LEN=16, 16-scff chain model, start, then 0xA5 and 0x3C back-to-back -> sc_en high 32 consecutive cycles; sc_out for the first 16 = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; done pulse with err=0; chain contents unchanged after VERIFY.
REQ-028 Same words with data_valid low for 3 cycles between them -> sc_en low for exactly those 3 cycles; final chain contents are identical and err=0.
REQ-029 0xA5, 0x3C with the bench forcing sc_in=0 during VERIFY -> done=1 with err=1; err stays 1 in IDLE until the next start.
REQ-030 Reset asserted after 5 bits of LOAD -> next cycle busy=0, sc_en=0, data_ready=0; a subsequent full load completes with err=0.
REQ-031 start pulsed during LOAD and VERIFY, and data_valid held high in IDLE -> no restart, no word accepted, and the sequence length is still 2*CHAIN_LEN shift cycles.
REQ-032 All-zero words with CHAIN_LEN=64 -> crc_wr=0x00, 64+64 sc_en cycles, err=0.
